line_word_loader: RTL and testbench
===================================

// Module: line_word_loader
// PURPOSE
//   Upstream sequencer for the single-entry 64-byte line buffer of compressor Stage 1. Accepts a
//   valid/ready stream of 32-bit words and drives the buffer's write port (w_en/word_index/w_data)
//   one word per cycle. Zero-pads short lines and hands each completed line to the compressor
//   with a line_valid/line_ready handshake. Blocks new writes while a line is held.
// PARAMETERS
//   DATA_WIDTH       32  bits per word (matches line buffer word width)
//   WORDS_PER_ENTRY  16  words per line; power of two >= 2; IW = $clog2(WORDS_PER_ENTRY)
// PORTS
//   clk          in   1            clock; all state updates on rising edge
//   rst          in   1            asynchronous, active-high reset
//   in_valid     in   1            upstream word valid
//   in_ready     out  1            loader can accept a word this cycle
//   in_data      in   DATA_WIDTH   upstream word
//   in_last      in   1            final word of the current line (sampled only on accept)
//   w_en         out  1            line buffer write enable
//   word_index   out  IW           line buffer word position
//   w_data       out  DATA_WIDTH   line buffer write data
//   line_valid   out  1            complete line present in buffer (registered)
//   line_ready   in   1            compressor consumes the line
//   line_words   out  IW+1         number of real (non-pad) words in held line, 1..WORDS_PER_ENTRY
//   busy         out  1            state != FILL or idx != 0 (line in progress or held)
// BEHAVIOUR
//   - FSM states FILL, PAD, HOLD; index counter idx (IW bits); word counter cnt (IW+1 bits).
//   - Reset (async): state=FILL, idx=0, cnt=0, line_valid=0, line_words=0, busy=0.
//     in_ready = (state==FILL) & ~rst, so in_ready=0 and w_en=0 while rst is high.
//     Buffer contents are not cleared (stale data is harmless; line_valid=0).
//   - Accept = in_valid & in_ready.
//   - FILL: w_en=accept, word_index=idx, w_data=in_data (combinational pass-through).
//     The buffer captures the word on the same edge. On accept: idx++, cnt++.
//       accept & idx==WORDS_PER_ENTRY-1 (in_last ignored) -> HOLD, line_words=WORDS_PER_ENTRY.
//       accept & in_last & idx<WORDS_PER_ENTRY-1 -> PAD, line_words=idx+1.
//       in_valid low -> bubble, no state change.
//   - PAD: in_ready=0, w_en=1, w_data=0, word_index=idx; idx++ each cycle.
//     Writing idx==WORDS_PER_ENTRY-1 -> HOLD. Pad takes WORDS_PER_ENTRY-1-k cycles after real
//     word k is accepted.
//   - HOLD: line_valid=1, in_ready=0, w_en=0. line_words and buffer contents stay stable.
//     line_valid & line_ready -> FILL, idx=0, cnt=0, line_valid=0 on the next edge.
//     line_valid never drops without line_ready.
//   - Latency: line_valid rises on the edge after the final buffer write (real or pad).
//     Full-rate throughput is WORDS_PER_ENTRY+1 cycles per line with line_ready held high.
//     No accept occurs in the handoff cycle.
//   - w_data=0 and word_index=idx whenever w_en=0.
//   - idx wrap to 0 happens only via HOLD->FILL.
//   - Reset mid-fill/pad/hold: partial line discarded; next accepted word goes to index 0.
// TESTING
//   1) 16 words 0x1000+i back-to-back, line_ready=1 -> w_en on 16 consecutive cycles, idx 0..15;
//      line_valid on cycle after 16th accept; line_words=16; buffer word i = 0x1000+i.
//   2) 5 words 0xA0..0xA4, in_last on 5th -> 11 PAD cycles write 0 to idx 5..15, in_ready=0;
//      then line_valid=1 with line_words=5.
//   3) line_ready low 10 cycles in HOLD with in_valid=1 -> in_ready=0, w_en=0, line_valid and
//      line_words stable; line_ready=1 -> next cycle FILL, first new word lands at idx 0.
//   4) in_valid toggles 1/0 each cycle over a 16-word line -> writes only on accepts, indices
//      contiguous 0..15, line_valid after 16th accept.
//   5) rst pulse after 7 accepted words -> line_valid=0, in_ready=0 during rst; next line
//      starts at idx 0 and yields line_words=16.
//   6) in_last on word 15 -> no PAD cycles, behaviour identical to scenario 1.

Source files
------------

// File: rtl/line_word_loader.sv
// line_word_loader
//   Feeds the single-entry line buffer of compressor Stage 1. It accepts a
//   valid/ready stream of words and writes them into the buffer, one word per
//   cycle. A line that ends early is filled with zero words. Each finished
//   line is offered to the compressor through line_valid/line_ready, and no
//   new words are accepted while that line is held.
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last   upstream word stream
//   w_en/word_index/w_data         line buffer write port
//   line_valid/line_ready          handoff of a completed line
//   line_words                     real (non-pad) word count of held line
//   busy                           line in progress or held
module line_word_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_ENTRY = 16,
  localparam int IW             = $clog2(WORDS_PER_ENTRY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  w_en,
  output logic [IW-1:0]         word_index,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [IW:0]           line_words,
  output logic                  busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_ENTRY - 1);
  localparam logic [IW:0]   LW_FULL  = (IW + 1)'(WORDS_PER_ENTRY);

  typedef enum logic [1:0] {FILL, PAD, HOLD} state_t;

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic [IW:0]     cnt;
  logic            accept;

  always_comb begin
    in_ready = (state == FILL) & ~rst;
    accept   = in_valid & in_ready;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      FILL: begin
        if (accept) begin
          if (idx == LAST_IDX) next_state = HOLD;
          else if (in_last)    next_state = PAD;
        end
      end
      PAD: begin
        if (idx == LAST_IDX) next_state = HOLD;
      end
      HOLD: begin
        if (line_valid & line_ready) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  // Index/count/line registers. idx parks on the last position when the line
  // completes so that the only return to 0 is the HOLD->FILL handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      cnt        <= '0;
      line_words <= '0;
      line_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (idx == LAST_IDX) begin
              line_words <= LW_FULL;
              line_valid <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              if (in_last) line_words <= cnt + 1'b1;
            end
          end
        end
        PAD: begin
          if (idx == LAST_IDX) line_valid <= 1'b1;
          else                 idx        <= idx + 1'b1;
        end
        HOLD: begin
          if (line_valid & line_ready) begin
            idx        <= '0;
            cnt        <= '0;
            line_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: write data is forced to zero whenever no write happens
  always_comb begin
    w_en       = 1'b0;
    w_data     = '0;
    word_index = idx;
    unique case (state)
      FILL: begin
        w_en   = accept;
        w_data = accept ? in_data : '0;
      end
      PAD: begin
        w_en = 1'b1;
      end
      default: ;
    endcase
    busy = (state != FILL) | (idx != '0);
  end

endmodule

// File: tb/tb_line_word_loader.sv
// tb_line_word_loader
//   Randomized bench for line_word_loader. A transaction-level reference
//   tracks the words of the current line, how many buffer writes it has seen
//   and whether a completed line is on offer; every output is compared to it
//   each cycle, and the captured buffer image is compared to the line's words
//   followed by zero padding when the line is offered.
module tb_line_word_loader;

  localparam int DW = 32;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          w_en;
  logic [IW-1:0] word_index;
  logic [DW-1:0] w_data;
  logic          line_valid;
  logic          line_ready = 1'b0;
  logic [IW:0]   line_words;
  logic          busy;

  line_word_loader #(.DATA_WIDTH(DW), .WORDS_PER_ENTRY(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .w_en(w_en), .word_index(word_index), .w_data(w_data),
    .line_valid(line_valid), .line_ready(line_ready),
    .line_words(line_words), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } item_t;

  item_t         src[$];
  logic [DW-1:0] cur_words[$];
  logic [DW-1:0] cap_img[N];
  bit            held;
  bit            padding;
  bit            lw_zero;
  int            wr_count;
  int            nwords;

  task automatic model_reset();
    held     = 1'b0;
    padding  = 1'b0;
    lw_zero  = 1'b1;
    wr_count = 0;
    nwords   = 0;
    cur_words.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs, then advance the model
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit l, input bit r,
                       output bit acc);
    bit            exp_ready;
    bit            exp_wen;
    logic [DW-1:0] exp_wdata;
    @(negedge clk);
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    line_ready = r;
    #1;
    exp_ready = !held && !padding;
    acc       = v && exp_ready;
    exp_wen   = padding || acc;
    exp_wdata = padding ? '0 : (acc ? d : '0);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("w_en", 64'(w_en), 64'(exp_wen));
    check("w_data", 64'(w_data), 64'(exp_wdata));
    check("line_valid", 64'(line_valid), 64'(held));
    check("busy", 64'(busy), 64'(held || padding || wr_count != 0));
    if (!held) check("word_index", 64'(word_index), 64'(wr_count));
    if (held)         check("line_words", 64'(line_words), 64'(nwords));
    else if (lw_zero) check("line_words_rst", 64'(line_words), 64'd0);
    if (w_en) cap_img[word_index] = w_data;

    if (held) begin
      if (r) begin
        held     = 1'b0;
        wr_count = 0;
      end
    end else if (exp_wen) begin
      if (acc) cur_words.push_back(d);
      wr_count++;
      if (wr_count == N) begin
        held    = 1'b1;
        padding = 1'b0;
        lw_zero = 1'b0;
        nwords  = cur_words.size();
        for (int i = 0; i < N; i++)
          check($sformatf("buf[%0d]", i), 64'(cap_img[i]),
                64'((i < nwords) ? cur_words[i] : '0));
        cur_words.delete();
      end else if (acc && l) begin
        padding = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_line_valid", 64'(line_valid), 64'd0);
    check("rst_line_words", 64'(line_words), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_in_ready2", 64'(in_ready), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    model_reset();
    src.delete();
  endtask

  task automatic push_line(input int n, input logic [DW-1:0] base, input bit last_full);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.data = base + DW'(i);
      it.last = (i == n - 1) && (n < N || last_full);
      src.push_back(it);
    end
  endtask

  // vmode: 0 random with vpct, 1 toggling 1/0 each cycle
  task automatic run(input string name, input int vpct, input bit vtoggle, input int rpct,
                     input bit stop_hold, input int budget);
    int k = 0;
    bit acc, v, l, r;
    logic [DW-1:0] d;
    while (k < budget) begin
      if (stop_hold && held) break;
      if (!stop_hold && src.size() == 0 && !held && !padding && wr_count == 0) break;
      v = (src.size() > 0) && (vtoggle ? (k % 2 == 0) : ($urandom_range(99) < vpct));
      d = (src.size() > 0) ? src[0].data : $urandom;
      l = (src.size() > 0) ? src[0].last : 1'b0;
      r = ($urandom_range(99) < rpct);
      cycle(v, d, l, r, acc);
      if (acc) void'(src.pop_front());
      k++;
    end
    check({name, "_budget"}, 64'(k < budget), 64'd1);
  endtask

  initial begin
    bit acc;
    int got;
    int k;
    model_reset();
    #2;
    do_reset();

    // Full line back-to-back, handoff accepted immediately
    push_line(16, 32'h1000, 1'b0);
    run("full", 100, 1'b0, 100, 1'b0, 60);

    // Short line with zero padding
    push_line(5, 32'hA0, 1'b0);
    run("short", 100, 1'b0, 100, 1'b0, 60);

    // Held line with compressor stalled and upstream pushing
    push_line(3, 32'h300, 1'b0);
    run("to_hold", 100, 1'b0, 0, 1'b1, 60);
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'hDEAD0000 + DW'(i), 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hBEEF, 1'b0, 1'b1, acc);
    push_line(16, 32'h2000, 1'b0);
    run("after_hold", 100, 1'b0, 100, 1'b0, 60);

    // Toggling valid
    push_line(16, 32'h4000, 1'b0);
    run("toggle", 0, 1'b1, 100, 1'b0, 80);

    // Reset in the middle of a line
    got = 0;
    k = 0;
    while (got < 7 && k < 50) begin
      cycle(1'b1, 32'h5000 + DW'(got), 1'b0, 1'b1, acc);
      if (acc) got++;
      k++;
    end
    check("mid_accepts", 64'(got), 64'd7);
    do_reset();
    push_line(16, 32'h6000, 1'b0);
    run("post_rst", 100, 1'b0, 100, 1'b0, 60);

    // in_last on the final word of a full line
    push_line(16, 32'h7000, 1'b1);
    run("last15", 100, 1'b0, 100, 1'b0, 60);

    // Random traffic
    for (int n = 0; n < 24; n++)
      push_line(int'($urandom_range(1, N)), $urandom, 1'($urandom_range(1)));
    run("random", 70, 1'b0, 60, 1'b0, 3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
